// File: rtl/ser2par.sv
// ser2par: MSB-first serial-to-parallel receiver with framing-error detection.
module ser2par #(
  parameter int WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ser,
  input  logic                   start,
  output logic [WORD_LENGTH-1:0] par,
  output logic                   valid,
  output logic                   busy,
  output logic                   err
);
  localparam int CW = WORD_LENGTH > 2 ? $clog2(WORD_LENGTH) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [WORD_LENGTH-1:0] shreg;
  logic [WORD_LENGTH-1:0] next_word;
  assign next_word = {shreg[WORD_LENGTH-2:0], ser};
  assign busy = state == SHIFT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      par   <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      shreg <= (state == IDLE && !start) ? shreg : next_word;
      if (start) begin
        // a start while busy aborts the frame and begins a new one on this bit
        err   <= state == SHIFT;
        cnt   <= CW'(1);
        state <= SHIFT;
      end else if (state == SHIFT) begin
        if (cnt == CW'(WORD_LENGTH - 1)) begin
          par   <= next_word;
          valid <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ser2par.sv
// tb_ser2par: directed checks of ser2par plus transmitter-paired streaming at W=8 and W=4.
module tb_ser2par;
  logic clk = 0;
  logic reset = 1;
  logic s_start = 0, s_ser = 0, e2e = 0;
  logic load8 = 0, load4 = 0;
  logic [7:0] word8 = 0;
  logic [3:0] word4 = 0;
  logic t8_d1, t8_d2, t8_o, t4_d1, t4_d2, t4_o;
  logic [7:0] t8_buf;
  logic [3:0] t4_buf;
  logic start8, ser8, valid8, busy8, err8, valid4, busy4, err4;
  logic [7:0] par8;
  logic [3:0] par4;
  int checks = 0, errors = 0, r8 = 0, r4 = 0;
  logic [7:0] q8[$];
  logic [3:0] q4[$];
  logic mq[$];
  logic [7:0] m_par = 0;
  logic m_valid = 0, m_err = 0;

  always #5 clk = ~clk;

  assign start8 = e2e ? t8_d2 : s_start;
  assign ser8   = e2e ? t8_o : s_ser;

  ser2par #(.WORD_LENGTH(8)) dut8 (.clk(clk), .reset(reset), .ser(ser8), .start(start8),
    .par(par8), .valid(valid8), .busy(busy8), .err(err8));
  ser2par #(.WORD_LENGTH(4)) dut4 (.clk(clk), .reset(reset), .ser(t4_o), .start(t4_d2),
    .par(par4), .valid(valid4), .busy(busy4), .err(err4));

  // transmitters: buffer loads on load, serial output registered a cycle later, start = load delayed 2
  always @(posedge clk) begin
    if (reset) begin
      t8_d1 <= 0; t8_d2 <= 0; t8_buf <= 0; t8_o <= 0;
      t4_d1 <= 0; t4_d2 <= 0; t4_buf <= 0; t4_o <= 0;
    end else begin
      t8_d1 <= load8; t8_d2 <= t8_d1; t8_buf <= load8 ? word8 : t8_buf << 1; t8_o <= t8_buf[7];
      t4_d1 <= load4; t4_d2 <= t4_d1; t4_buf <= load4 ? word4 : t4_buf << 1; t4_o <= t4_buf[3];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // compare outputs, then advance the model with the inputs the next edge will sample
  always @(negedge clk) begin
    logic [7:0] w;
    chk("par", par8, m_par);
    chk("valid", valid8, m_valid);
    chk("busy", busy8, mq.size() != 0);
    chk("err", err8, m_err);
    chk("err4", err4, 0);
    if (e2e && valid8) begin
      r8++;
      if (q8.size() == 0) chk("rx8_extra", par8, 0); else chk("rx8", par8, q8.pop_front());
    end
    if (valid4) begin
      r4++;
      if (q4.size() == 0) chk("rx4_extra", par4, 0); else chk("rx4", par4, q4.pop_front());
    end
    m_valid = 0;
    m_err = 0;
    if (reset) begin
      mq.delete();
      m_par = 0;
    end else if (start8) begin
      m_err = mq.size() != 0;
      mq.delete();
      mq.push_back(ser8);
    end else if (mq.size() != 0) begin
      mq.push_back(ser8);
      if (mq.size() == 8) begin
        for (int i = 0; i < 8; i++) w[7-i] = mq[i];
        m_par = w;
        m_valid = 1;
        mq.delete();
      end
    end
  end

  task automatic step(input logic s, input logic d);
    s_start = s;
    s_ser = d;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] w, input logic exp_err, input logic [7:0] hold);
    for (int i = 7; i >= 0; i--) begin
      step(i == 7, w[i]);
      if (i == 7) begin
        chk("err_at_start", err8, exp_err);
        if (exp_err) chk("par_hold", par8, hold);
      end
    end
    chk("valid_end", valid8, 1);
    chk("par_end", par8, w);
    chk("busy_end", busy8, 0);
  endtask

  initial begin
    step(0, 0);
    step(0, 0);
    chk("rst_par", par8, 0);
    chk("rst_busy", busy8, 0);
    reset = 0;
    step(0, 0);
    frame(8'hA5, 0, 0);
    repeat (20) step(0, 1'($urandom));
    chk("a5_hold", par8, 8'hA5);
    chk("a5_valid_low", valid8, 0);
    frame(8'h3C, 0, 0);
    frame(8'hFF, 0, 0);
    step(0, 0);
    chk("b2b_valid_once", valid8, 0);
    step(1, 0);
    repeat (3) step(0, 0);
    frame(8'h81, 1, 8'hFF);
    step(0, 0);
    step(1, 1);
    for (int i = 5; i >= 0; i--) step(0, 1'(8'hC3 >> i));
    chk("last_no_valid", valid8, 0);
    frame(8'h42, 1, 8'h81);
    step(0, 0);
    step(1, 1);
    repeat (4) step(0, 1);
    reset = 1;
    step(0, 0);
    reset = 0;
    chk("mid_rst_par", par8, 0);
    chk("mid_rst_valid", valid8, 0);
    chk("mid_rst_err", err8, 0);
    chk("mid_rst_busy", busy8, 0);
    step(0, 1);
    frame(8'h5A, 0, 0);
    step(0, 0);
    e2e = 1;
    for (int k = 0; k < 1000; k++)
      for (int c = 0; c < 8; c++) begin
        load8 = c == 0;
        if (load8) begin
          word8 = 8'($urandom);
          q8.push_back(word8);
        end
        load4 = (c % 4 == 0) && k < 500;
        if (load4) begin
          word4 = 4'($urandom);
          q4.push_back(word4);
        end
        @(posedge clk);
        #1;
      end
    load8 = 0;
    load4 = 0;
    repeat (20) step(0, 0);
    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    chk("rx8_count", r8, 1000);
    chk("rx4_count", r4, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
